// File: rtl/interrupt_ctrl_pkg.sv
// Shared types and helpers for the multi-channel interrupt controller.
package interrupt_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } arb_state_t;

    localparam logic MODE_LEVEL = 1'b0;
    localparam logic MODE_EDGE  = 1'b1;

    // Index of the lowest set bit; 0 when nothing is set.
    function automatic int lowest_idx(input logic [31:0] vec);
        int idx;
        idx = 0;
        for (int i = 31; i >= 0; i--) begin
            if (vec[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/int_ch_cell.sv
// One interrupt channel: source select, rising-edge detect and sticky status bit.
module int_ch_cell
    import interrupt_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic int_in,
    input  logic int_mode,
    input  logic int_set_en,
    input  logic int_set_value,
    input  logic int_en,
    input  logic int_clr,
    input  logic ack_clr,
    output logic int_state
);

    logic src;
    logic src_d;
    logic rise;
    logic hit;

    assign src  = int_set_en ? int_set_value : int_in;
    // src_d resets low, so a source already high at reset release counts as an edge.
    assign rise = src & ~src_d;
    assign hit  = int_en & ((int_mode == MODE_EDGE) ? rise : src);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_d     <= 1'b0;
            int_state <= 1'b0;
        end else begin
            src_d <= src;
            if (hit)
                int_state <= 1'b1;
            else if (int_clr || ack_clr)
                int_state <= 1'b0;
        end
    end

endmodule

// File: rtl/interrupt_ctrl_mc.sv
// Multi-channel interrupt controller: per-channel cells, merged IRQ line and
// a fixed-priority vector handshake that auto-clears the acknowledged channel.
module interrupt_ctrl_mc
    import interrupt_ctrl_pkg::*;
#(
    parameter int CH_NUM = 8,
    parameter int ID_W   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CH_NUM-1:0] int_in,
    input  logic [CH_NUM-1:0] int_mode,
    input  logic [CH_NUM-1:0] int_set_en,
    input  logic [CH_NUM-1:0] int_set_value,
    input  logic [CH_NUM-1:0] int_en,
    input  logic [CH_NUM-1:0] int_mask,
    input  logic [CH_NUM-1:0] int_clr,
    output logic [CH_NUM-1:0] int_state,
    output logic [CH_NUM-1:0] int_pending,
    output logic              irq_out,
    output logic              irq_valid,
    output logic [ID_W-1:0]   irq_id,
    input  logic              irq_ack
);

    arb_state_t        state;
    logic [CH_NUM-1:0] ack_clr;

    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        int_ch_cell u_cell (
            .clk          (clk),
            .rst_n        (rst_n),
            .int_in       (int_in[i]),
            .int_mode     (int_mode[i]),
            .int_set_en   (int_set_en[i]),
            .int_set_value(int_set_value[i]),
            .int_en       (int_en[i]),
            .int_clr      (int_clr[i]),
            .ack_clr      (ack_clr[i]),
            .int_state    (int_state[i])
        );
    end

    assign int_pending = int_state & ~int_mask;

    // The acknowledged channel is cleared in the same edge that drops irq_valid.
    assign ack_clr = (state == REQ && irq_ack) ? (CH_NUM'(1) << irq_id) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            irq_out <= 1'b0;
        else
            irq_out <= |int_pending;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            irq_valid <= 1'b0;
            irq_id    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|int_pending) begin
                        irq_id    <= ID_W'(lowest_idx(32'(int_pending)));
                        irq_valid <= 1'b1;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (irq_ack) begin
                        irq_valid <= 1'b0;
                        state     <= GAP;
                    end
                end
                GAP:     state <= IDLE;
                default: begin
                    irq_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/interrupt_ctrl_mc.md
Name: interrupt_ctrl_mc

Overview:
Multi-channel successor to the single-bit interrupt control cell. It adds the following per channel:
- level or rising-edge source mode
- force-set
- enable and mask
- sticky status with write-1-to-clear

It merges all channels into one registered IRQ line. A fixed-priority vector stage presents the winning channel ID through a valid/ack handshake, and the handshake auto-clears that channel's status. The block sits between peripheral interrupt sources and the CPU or register-bank interface.

Parameters:
CH_NUM, 8, number of interrupt channels (1..32)
ID_W, $clog2(CH_NUM) (min 1), width of irq_id

Ports:
clk  in  1  clock
rst_n  in  1  reset
int_in  in  CH_NUM  raw interrupt sources, synchronous to clk
int_mode  in  CH_NUM  per channel: 0 = level, 1 = rising edge
int_set_en  in  CH_NUM  per channel: force-set override select
int_set_value  in  CH_NUM  per channel: forced source value when int_set_en=1
int_en  in  CH_NUM  per channel: enable; 0 blocks status capture
int_mask  in  CH_NUM  per channel: 1 = masked from irq_out and arbitration
int_clr  in  CH_NUM  write-1-to-clear strobe for int_state
int_state  out  CH_NUM  sticky status register
int_pending  out  CH_NUM  int_state & ~int_mask (combinational)
irq_out  out  1  registered OR of int_pending
irq_valid  out  1  vector handshake valid
irq_id  out  ID_W  winning channel index, valid while irq_valid=1
irq_ack  in  1  vector handshake acknowledge

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low. All flops clear on reset: int_state=0, src_d=0, irq_out=0, irq_valid=0, irq_id=0, FSM=IDLE. Reset mid-handshake drops irq_valid immediately.
- src[i] = int_set_en[i] ? int_set_value[i] : int_in[i].
- src_d[i] is a register of src[i]. rise[i] = src[i] & ~src_d[i].
- Because src_d resets to 0, a source already high at reset release registers as an edge in the first cycle.
- hit[i] = int_en[i] & (int_mode[i] ? rise[i] : src[i]).
- int_state[i] next-state priority:
  1. hit[i] → 1
  2. else int_clr[i] or ack_clr[i] → 0
  3. else hold.
  Set wins over any simultaneous clear.
- Masking affects only int_pending, irq_out and arbitration. A masked channel still captures status.
- irq_out is registered from |int_pending. For a level source rising at cycle t, int_state=1 after edge t and irq_out=1 after edge t+1.
- FSM states:
  - IDLE: if int_pending≠0, latch irq_id = lowest set index of int_pending, assert irq_valid, go to REQ.
  - REQ: irq_valid=1 and irq_id held stable until irq_ack=1. On ack, ack_clr[irq_id] pulses for one cycle, irq_valid drops, go to GAP.
  - GAP: one idle cycle so the cleared status propagates, then IDLE.
- Masking or clearing the latched channel during REQ does not retract irq_valid or change irq_id. The ack clear then has no effect, since the bit is already 0.
- A level source still high at ack re-sets int_state in the same cycle, because set wins. It is re-vectored after GAP.
- irq_ack outside REQ is ignored.
- Minimum spacing between vectors is 3 cycles: valid, ack, gap.

Decomposition:
- Package interrupt_ctrl_pkg holds:
  - FSM state encodings: IDLE=2'd0, REQ=2'd1, GAP=2'd2
  - mode constants: MODE_LEVEL=1'b0, MODE_EDGE=1'b1
  - lowest-index priority-encoder function
- Sub-module int_ch_cell implements one channel: source mux, edge detect, hit logic, sticky state register. It is instantiated CH_NUM times in a generate loop.
- The top module holds the irq_out register, the arbiter FSM and ack_clr decode.

Test Plan:
1. Reset and level capture. Release reset with all inputs 0, then drive int_in=8'h04, int_en=8'hFF, mode=0 at cycle 5.
   → int_state=8'h04 after edge 5; irq_out=1 and irq_valid=1 with irq_id=2 after edge 6.
2. Edge mode. Set int_mode[3]=1 and hold int_in[3]=1 for 10 cycles.
   → int_state[3] set exactly once. Pulsing int_clr[3] while the input stays high clears it, and it stays 0.
3. Priority and handshake. Set int_state bits 1, 5 and 6.
   → irq_id=1 until ack. After ack plus GAP, irq_id=5, then 6. irq_out falls 1 cycle after the last state clears.
4. Mask. Set int_mask=8'h02 with int_state=8'h02.
   → int_pending=0, irq_out=0, no irq_valid. Unmasking gives irq_out=1 after 1 cycle.
5. Simultaneous events, three cases:
   - int_clr[0]=1 and hit[0]=1 in the same cycle → int_state[0]=1.
   - Ack of channel 4 while its level source is still high → int_state[4] stays 1 and is re-vectored.
   - int_set_en[7]=1 with int_set_value[7]=1 and int_en[7]=0 → no capture.
6. Reset mid-handshake. Assert rst_n=0 while irq_valid=1 and irq_id=3.
   → All outputs are 0 asynchronously. After release, a held level on channel 3 is re-vectored with irq_valid=1 two cycles later.
